// File: rtl/dds_pkg.sv
// dds_pkg: shared constants, config record and quadrant decode helper for
// the dual-phase DDS source.
//   DDS_MID          offset-binary midscale for a 14-bit DAC
//   DDS_AMP_FULL     full-scale Q0.16 amplitude
//   dds_cfg_t        shadow config record {ftw, phase, amp, sync}
//   dds_quarter_addr quarter-wave mirror of the in-quadrant index
package dds_pkg;

  localparam int              DDS_PHASE_W  = 32;
  localparam logic [13:0]     DDS_MID      = 14'h2000;
  localparam logic [15:0]     DDS_AMP_FULL = 16'hFFFF;

  typedef struct packed {
    logic [DDS_PHASE_W-1:0] ftw;
    logic [DDS_PHASE_W-1:0] phase;
    logic [15:0]            amp;
    logic                   sync;
  } dds_cfg_t;

  // Odd quadrants walk the quarter-wave table backwards. The caller passes
  // the in-quadrant index zero-extended to 16 bits and keeps the low bits.
  function automatic logic [15:0] dds_quarter_addr(input logic [1:0]  quad,
                                                   input logic [15:0] lo);
    return quad[0] ? ~lo : lo;
  endfunction

endpackage

// File: rtl/dds_sine_quarter_rom.sv
// dds_sine_quarter_rom: dual-read-port quarter-wave sine magnitude ROM.
// Entry k holds round((2^MAG_W-1) * sin(pi/2 * (k+0.5) / 2^LUT_AW)),
// computed at elaboration. Both read ports are registered (1-cycle latency).
//   clk_dac         clock
//   addr_a, addr_b  read addresses
//   data_a, data_b  registered magnitudes
module dds_sine_quarter_rom #(
  parameter int LUT_AW = 10,
  parameter int MAG_W  = 13
) (
  input  logic              clk_dac,
  input  logic [LUT_AW-1:0] addr_a,
  input  logic [LUT_AW-1:0] addr_b,
  output logic [MAG_W-1:0]  data_a,
  output logic [MAG_W-1:0]  data_b
);

  localparam int DEPTH = 1 << LUT_AW;

  function automatic int sine_entry(input int k);
    real full;
    real ang;
    full = real'((1 << MAG_W) - 1);
    ang  = 3.14159265358979323846 * (real'(k) + 0.5) / (2.0 * real'(DEPTH));
    return $rtoi(full * $sin(ang) + 0.5);
  endfunction

  logic [MAG_W-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int V = sine_entry(k);
    assign rom[k] = MAG_W'(V);
  end

  always_ff @(posedge clk_dac) begin
    data_a <= rom[addr_a];
    data_b <= rom[addr_b];
  end

endmodule

// File: rtl/dds_dual_phase_gen.sv
// dds_dual_phase_gen: two-samples-per-clock DDS source for the DAC path.
// Optional feature macro: DDS_AMP_SCALE_EN (amplitude multiplier stage,
// latency 4; without it cfg_amp is ignored and latency is 3).
//   clk_dac, rst_n        clock, async active-low reset
//   enable                advance accumulator and emit samples
//   cfg_valid/cfg_ready   config handshake (ftw, phase, amp, sync)
//   dac_data_a_out/_b_out even/odd samples, offset binary
//   data_valid            output pair valid
module dds_dual_phase_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10,
  parameter int DATA_W  = 14
) (
  input  logic               clk_dac,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_ftw,
  input  logic [PHASE_W-1:0] cfg_phase,
  input  logic [15:0]        cfg_amp,
  input  logic               cfg_sync,
  output logic [DATA_W-1:0]  dac_data_a_out,
  output logic [DATA_W-1:0]  dac_data_b_out,
  output logic               data_valid
);

  localparam int IW = LUT_AW + 2;
  localparam int MW = DATA_W - 1;
  localparam logic [DATA_W-1:0] MID = {1'b1, {MW{1'b0}}};

  function automatic logic signed [DATA_W-1:0] apply_sign(input logic [MW-1:0] m,
                                                          input logic neg);
    logic signed [DATA_W-1:0] v;
    v = $signed({1'b0, m});
    return neg ? -v : v;
  endfunction

  // Adding midscale to a two's complement sample is an MSB flip.
  function automatic logic [DATA_W-1:0] to_offset(input logic signed [DATA_W-1:0] s);
    return {~s[DATA_W-1], s[DATA_W-2:0]};
  endfunction

`ifdef DDS_AMP_SCALE_EN
  // (s * amp) >>> 16 with floor rounding; |result| <= |s| so no overflow.
  function automatic logic signed [DATA_W-1:0] scale_amp(input logic signed [DATA_W-1:0] s,
                                                         input logic [15:0] a);
    logic signed [DATA_W+16:0] prod;
    prod = s * $signed({1'b0, a});
    return DATA_W'(prod >>> 16);
  endfunction
`endif

  logic               apply;
  dds_cfg_t           sh;
  logic [PHASE_W-1:0] acc, ftw_q, phase_q;
  logic [15:0]        amp_q;
  logic [PHASE_W-1:0] ftw_e, phase_e, pa_c, pb_c;
  logic               accept;

  // In the apply cycle the shadow values take effect combinationally, so the
  // phase register and accumulator step of that cycle already use them.
  assign accept  = cfg_valid && cfg_ready;
  assign ftw_e   = apply ? PHASE_W'(sh.ftw)   : ftw_q;
  assign phase_e = apply ? PHASE_W'(sh.phase) : phase_q;
  assign pa_c    = acc + phase_e;
  assign pb_c    = acc + ftw_e + phase_e;

  always_ff @(posedge clk_dac or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ftw_q     <= '0;
      phase_q   <= '0;
      amp_q     <= DDS_AMP_FULL;
      cfg_ready <= 1'b1;
      apply     <= 1'b0;
    end else begin
      apply     <= accept;
      cfg_ready <= !accept;
      if (apply) begin
        ftw_q   <= PHASE_W'(sh.ftw);
        phase_q <= PHASE_W'(sh.phase);
        amp_q   <= sh.amp;
      end
      if (apply && sh.sync)
        acc <= '0;
      else if (enable)
        acc <= acc + {ftw_e[PHASE_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_dac) begin
    if (accept)
      sh <= '{ftw: DDS_PHASE_W'(cfg_ftw), phase: DDS_PHASE_W'(cfg_phase),
              amp: cfg_amp, sync: cfg_sync};
  end

  // ---- stage p0: phase register ----
  logic          vld_p0, vld_p1;
  logic [IW-1:0] idx_a_p0, idx_b_p0;
  logic          sign_a_p1, sign_b_p1;
  logic [MW-1:0] m_a_p1, m_b_p1;
  logic [LUT_AW-1:0] addr_a, addr_b;

  always_ff @(posedge clk_dac) begin
    idx_a_p0  <= pa_c[PHASE_W-1 -: IW];
    idx_b_p0  <= pb_c[PHASE_W-1 -: IW];
    sign_a_p1 <= idx_a_p0[IW-1];
    sign_b_p1 <= idx_b_p0[IW-1];
  end

  // ---- stage p1: ROM read ----
  assign addr_a = LUT_AW'(dds_quarter_addr(idx_a_p0[IW-1 -: 2], 16'(idx_a_p0[LUT_AW-1:0])));
  assign addr_b = LUT_AW'(dds_quarter_addr(idx_b_p0[IW-1 -: 2], 16'(idx_b_p0[LUT_AW-1:0])));

  dds_sine_quarter_rom #(.LUT_AW(LUT_AW), .MAG_W(MW)) u_rom (
    .clk_dac (clk_dac),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .data_a  (m_a_p1),
    .data_b  (m_b_p1)
  );

`ifdef DDS_AMP_SCALE_EN
  logic [15:0] amp_p0, amp_p1, amp_p2;
  logic        vld_p2;
  logic signed [DATA_W-1:0] s_a_p2, s_b_p2;

  // Amplitude rides with its sample so a new amp lands on the same pair as
  // a new ftw/phase.
  always_ff @(posedge clk_dac) begin
    amp_p0 <= apply ? sh.amp : amp_q;
    amp_p1 <= amp_p0;
    amp_p2 <= amp_p1;
    // ---- stage p2: sign apply ----
    s_a_p2 <= apply_sign(m_a_p1, sign_a_p1);
    s_b_p2 <= apply_sign(m_b_p1, sign_b_p1);
  end
`else
  logic unused_amp;
  assign unused_amp = ^{amp_q, sh.amp, cfg_amp};
`endif

  logic unused_phase_lo;
  assign unused_phase_lo = ^{pa_c[PHASE_W-IW-1:0], pb_c[PHASE_W-IW-1:0]};

  // ---- output register: scale (if present) and offset-binary conversion ----
  always_ff @(posedge clk_dac or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0         <= 1'b0;
      vld_p1         <= 1'b0;
`ifdef DDS_AMP_SCALE_EN
      vld_p2         <= 1'b0;
`endif
      data_valid     <= 1'b0;
      dac_data_a_out <= MID;
      dac_data_b_out <= MID;
    end else begin
      vld_p0 <= enable;
      vld_p1 <= vld_p0;
`ifdef DDS_AMP_SCALE_EN
      vld_p2         <= vld_p1;
      data_valid     <= vld_p2;
      dac_data_a_out <= vld_p2 ? to_offset(scale_amp(s_a_p2, amp_p2)) : MID;
      dac_data_b_out <= vld_p2 ? to_offset(scale_amp(s_b_p2, amp_p2)) : MID;
`else
      data_valid     <= vld_p1;
      dac_data_a_out <= vld_p1 ? to_offset(apply_sign(m_a_p1, sign_a_p1)) : MID;
      dac_data_b_out <= vld_p1 ? to_offset(apply_sign(m_b_p1, sign_b_p1)) : MID;
`endif
    end
  end

endmodule

// File: tb/tb_dds_dual_phase_gen.sv
// tb_dds_dual_phase_gen: directed + randomized bench for dds_dual_phase_gen.
// Expected samples come from sin() of the phase-bin centre, rounded, scaled
// with floor division, and delayed by the block latency.
module tb_dds_dual_phase_gen;
  import dds_pkg::*;

`ifdef DDS_AMP_SCALE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam real PI = 3.14159265358979323846;

  logic        clk_dac = 1'b0;
  logic        rst_n, enable, cfg_valid, cfg_sync, cfg_ready, data_valid;
  logic [31:0] cfg_ftw, cfg_phase;
  logic [15:0] cfg_amp;
  logic [13:0] dac_data_a_out, dac_data_b_out;

  dds_dual_phase_gen dut (
    .clk_dac(clk_dac), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ftw(cfg_ftw), .cfg_phase(cfg_phase), .cfg_amp(cfg_amp), .cfg_sync(cfg_sync),
    .dac_data_a_out(dac_data_a_out), .dac_data_b_out(dac_data_b_out),
    .data_valid(data_valid)
  );

  always #5 clk_dac = ~clk_dac;

  int n_assert = 0;
  int n_fail   = 0;

  // reference state
  logic [31:0] m_acc, m_ftw, m_phase, s_ftw, s_phase;
  logic [15:0] m_amp, s_amp;
  logic        m_ready, m_pend, s_sync;
  logic        ev [LAT];
  logic [13:0] ea [LAT];
  logic [13:0] eb [LAT];

  function automatic logic [13:0] sample_code(input logic [31:0] p, input logic [15:0] amp);
    int     bin;
    real    x;
    int     s;
    longint t, q;
    bin = int'(p >> 20);
    x   = 8191.0 * $sin(2.0 * PI * (real'(bin) + 0.5) / 4096.0);
    s   = (x < 0.0) ? -$rtoi(-x + 0.5) : $rtoi(x + 0.5);
`ifdef DDS_AMP_SCALE_EN
    t = longint'(s) * longint'(amp);
    q = t / 65536;
    if (t < 0 && q * 65536 != t) q = q - 1;
    s = int'(q);
`else
    t = longint'(amp);
    q = t;
`endif
    return 14'(s + 8192);
  endfunction

  task automatic model_reset();
    m_acc = 0; m_ftw = 0; m_phase = 0; m_amp = 16'hFFFF;
    m_ready = 1'b1; m_pend = 1'b0;
    for (int i = 0; i < LAT; i++) begin ev[i] = 1'b0; ea[i] = DDS_MID; eb[i] = DDS_MID; end
  endtask

  task automatic model_edge();
    logic [31:0] ef, ep;
    logic [15:0] eamp;
    ef   = m_pend ? s_ftw   : m_ftw;
    ep   = m_pend ? s_phase : m_phase;
    eamp = m_pend ? s_amp   : m_amp;
    for (int i = LAT - 1; i > 0; i--) begin ev[i] = ev[i-1]; ea[i] = ea[i-1]; eb[i] = eb[i-1]; end
    ev[0] = enable;
    ea[0] = enable ? sample_code(m_acc + ep, eamp) : DDS_MID;
    eb[0] = enable ? sample_code(m_acc + ef + ep, eamp) : DDS_MID;
    if (m_pend && s_sync) m_acc = 0;
    else if (enable)      m_acc = m_acc + 2 * ef;
    if (m_pend) begin
      m_ftw = s_ftw; m_phase = s_phase; m_amp = s_amp; m_pend = 1'b0; m_ready = 1'b1;
    end else if (cfg_valid && m_ready) begin
      s_ftw = cfg_ftw; s_phase = cfg_phase; s_amp = cfg_amp; s_sync = cfg_sync;
      m_pend = 1'b1; m_ready = 1'b0;
    end
  endtask

  task automatic tick();
    if (rst_n) model_edge(); else model_reset();
    @(posedge clk_dac);
    #1;
  endtask

  task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid"}, 14'(data_valid), 14'(ev[LAT-1]));
    chk({tag, " a"},     dac_data_a_out,  ea[LAT-1]);
    chk({tag, " b"},     dac_data_b_out,  eb[LAT-1]);
    chk({tag, " ready"}, 14'(cfg_ready),  14'(m_ready));
  endtask

  task automatic configure(input logic [31:0] f, input logic [31:0] p,
                           input logic [15:0] a, input logic s);
    cfg_valid = 1'b1; cfg_ftw = f; cfg_phase = p; cfg_amp = a; cfg_sync = s;
    tick(); cfg_valid = 1'b0; check_model("cfg accept");
    tick(); check_model("cfg apply");
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin tick(); check_model(tag); end
  endtask

`ifdef DDS_AMP_SCALE_EN
  localparam logic [13:0] Q_A0 = 14'h2005, Q_B0 = 14'h3FFE;
  localparam logic [13:0] H_A0 = 14'h2003, H_B0 = 14'h2FFF, H_A1 = 14'h1FFD, H_B1 = 14'h1000;
`else
  localparam logic [13:0] Q_A0 = 14'h2006, Q_B0 = 14'h3FFF;
  localparam logic [13:0] H_A0 = 14'h2006, H_B0 = 14'h3FFF, H_A1 = 14'h1FFA, H_B1 = 14'h0001;
`endif
  localparam logic [13:0] Q_A1 = 14'h1FFA, Q_B1 = 14'h0001;

  initial begin
    rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    cfg_ftw = '0; cfg_phase = '0; cfg_amp = '0; cfg_sync = 1'b0;
    s_ftw = '0; s_phase = '0; s_amp = '0; s_sync = 1'b0;
    model_reset();
    run("reset hold", 3);
    chk("reset a", dac_data_a_out, DDS_MID);
    chk("reset b", dac_data_b_out, DDS_MID);
    chk("reset valid", 14'(data_valid), 14'd0);
    chk("reset ready", 14'(cfg_ready), 14'd1);
    rst_n = 1'b1;
    run("idle", 2);

    // quarter-rate tone, full amplitude
    configure(32'h4000_0000, 32'h0, 16'hFFFF, 1'b1);
    enable = 1'b1;
    run("quarter fill", LAT);
    chk("quarter a0", dac_data_a_out, Q_A0);
    chk("quarter b0", dac_data_b_out, Q_B0);
    tick(); check_model("quarter");
    chk("quarter a1", dac_data_a_out, Q_A1);
    chk("quarter b1", dac_data_b_out, Q_B1);
    tick(); check_model("quarter");
    chk("quarter a2", dac_data_a_out, Q_A0);
    chk("quarter b2", dac_data_b_out, Q_B0);
    run("quarter", 4);

    // half amplitude, restarted from zero phase
    enable = 1'b0;
    configure(32'h4000_0000, 32'h0, 16'h8000, 1'b1);
    run("half drain", LAT);
    chk("half idle a", dac_data_a_out, DDS_MID);
    enable = 1'b1;
    run("half fill", LAT);
    chk("half a0", dac_data_a_out, H_A0);
    chk("half b0", dac_data_b_out, H_B0);
    tick(); check_model("half");
    chk("half a1", dac_data_a_out, H_A1);
    chk("half b1", dac_data_b_out, H_B1);

    // phase offset of half a turn, no stepping
    enable = 1'b0;
    configure(32'h0, 32'h8000_0000, 16'hFFFF, 1'b1);
    enable = 1'b1;
    run("phase fill", LAT + 3);
    chk("phase a", dac_data_a_out, 14'h1FFA);
    chk("phase b", dac_data_b_out, 14'h1FFA);

    // handshake: two offers back to back while running
    configure(32'h0123_4567, 32'h0, 16'hFFFF, 1'b0);
    cfg_valid = 1'b1; cfg_ftw = 32'h1000_0000; cfg_sync = 1'b0;
    tick(); check_model("hs first");
    chk("hs ready low", 14'(cfg_ready), 14'd0);
    cfg_ftw = 32'h2222_0000;
    tick(); check_model("hs ignored");
    chk("hs ready back", 14'(cfg_ready), 14'd1);
    tick(); check_model("hs second");
    cfg_valid = 1'b0;
    run("hs tone", LAT + 4);

    // enable gaps
    enable = 1'b1; tick(); check_model("gap");
    enable = 1'b0; tick(); check_model("gap");
    enable = 1'b1; tick(); check_model("gap");
    enable = 1'b0; tick(); check_model("gap");
    tick(); check_model("gap");
    enable = 1'b1; run("gap", LAT + 2);

    // randomized enable and config traffic
    for (int i = 0; i < 300; i++) begin
      enable    = ($urandom_range(0, 3) != 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_ftw   = $urandom;
      cfg_phase = $urandom;
      cfg_amp   = 16'($urandom);
      cfg_sync  = ($urandom_range(0, 3) == 0);
      tick(); check_model("random");
    end

    // asynchronous reset mid-stream with a config pending
    enable = 1'b1; cfg_valid = 1'b1; cfg_ftw = 32'h0777_0000; cfg_sync = 1'b0;
    tick(); check_model("pre reset");
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async rst a", dac_data_a_out, DDS_MID);
    chk("async rst b", dac_data_b_out, DDS_MID);
    chk("async rst valid", 14'(data_valid), 14'd0);
    chk("async rst ready", 14'(cfg_ready), 14'd1);
    tick(); check_model("in reset");
    rst_n = 1'b1;
    run("post reset", LAT + 3);
    chk("post reset a", dac_data_a_out, Q_A0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
